uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Shares the single UART transmitter between NUM_REQ byte producers, e.g. the switch-entry path, a loopback/echo path and a status reporter.
- Arbitrates round-robin with optional burst locking so multi-byte messages are not interleaved.
- Sequences the transmitter's start/done handshake and guards it with a watchdog.
- Sits between the producers and the variable-baud UART wrapper, in the same clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of grant_id; must be at least ceil(log2(NUM_REQ)).
- TIMEOUT_CYCLES, 2000000, maximum cycles allowed between tx_start and tx_done, and for the inter-byte gap inside a burst.
- CNT_W, 21, width of the watchdog counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester byte available
- req_data  in  8*NUM_REQ  byte for requester i in bits [8i+7:8i]
- req_last  in  NUM_REQ  byte is final of message; 0 locks grant
- req_ready  out  NUM_REQ  one-cycle accept strobe, at most one bit set
- tx_ready  in  1  transmitter idle and able to accept a start
- tx_done  in  1  one-cycle pulse when the transmitter finishes the stop bit
- tx_start  out  1  one-cycle start pulse to the transmitter
- tx_data  out  8  byte presented to the transmitter, held until the next load
- grant_id  out  ID_W  index of the current or last granted requester
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all outputs 0.
  - Priority pointer last=NUM_REQ-1, so requester 0 wins first.
  - lock=0, watchdog counter=0.
- All outputs are registered.
- Requester rule: hold valid/data/last stable until req_ready is seen; a byte transfers in the cycle where valid & ready are both high.
- IDLE:
  - If any req_valid, winner = first valid index searching last+1, last+2, … modulo NUM_REQ.
  - grant_id<=winner; go to LOAD.
- LOAD (1 cycle):
  - req_ready[grant_id]=1.
  - tx_data<=req_data[grant_id]; lock<=~req_last[grant_id].
  - Go to START.
- START:
  - Wait while tx_ready=0.
  - When tx_ready=1, pulse tx_start for 1 cycle, clear the counter and go to WAIT_DONE.
  - Latency is exactly 3 cycles from valid first seen in IDLE to tx_start, when tx_ready=1.
- WAIT_DONE:
  - Counter increments every cycle.
  - On tx_done: if lock=1 go to HOLD and clear the counter; else last<=grant_id and go to IDLE.
  - If tx_done is absent and counter==TIMEOUT_CYCLES-1: pulse timeout_err, lock<=0, last<=grant_id, go to IDLE.
- HOLD (burst in progress; other requesters are ignored):
  - If req_valid[grant_id]=1, go to LOAD; grant_id is unchanged.
  - Otherwise the counter increments; at TIMEOUT_CYCLES-1, pulse timeout_err, release the lock, last<=grant_id, go to IDLE.
- Simultaneous events:
  - tx_done in the same cycle as expiry: done wins, no error.
  - A requester dropping valid illegally before ready is not protected against; the byte in tx_data is whatever was sampled in LOAD.
- Fairness: after any completed or aborted message the pointer moves past the grantee, so N continuously valid requesters are each served once per N messages.
- tx_start never asserts while tx_ready=0 and never twice without an intervening tx_done or timeout.
- Reset mid-operation returns everything to reset values immediately; no tx_start is issued after rst_n falls.

Test Plan:
- Single byte: req_valid[2]=1, data 0x41, last=1, tx_ready=1.
  - Expect req_ready[2] and tx_start 2 and 3 cycles after valid; tx_data=0x41, grant_id=2.
  - tx_done after 100 cycles returns to IDLE, busy=0.
- Round-robin: all four valid with last=1 every byte, data 0x10+i.
  - Expect transmit order 0,1,2,3,0, with exactly one req_ready bit per LOAD.
- Burst lock: req0 sends 0xA0, 0xA1 (last=0), 0xA2 (last=1) while req1 is continuously valid.
  - Expect A0, A1, A2 back-to-back, then req1's byte.
- tx_ready held 0 for 50 cycles after LOAD.
  - Expect tx_start exactly one cycle after tx_ready rises, and tx_data stable throughout.
- Timeout: TIMEOUT_CYCLES=64, tx_done never arrives.
  - Expect timeout_err pulse 64 cycles after tx_start, then IDLE.
  - Next arbitration starts after the failed grantee.
  - Repeat with a HOLD gap of 64 cycles: same result.
- Reset in WAIT_DONE (rst_n low 3 cycles, asynchronously mid-cycle).
  - Expect all outputs 0 immediately.
  - After release, requester 0 has highest priority.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte producers,
// with burst locking for multi-byte messages and a start/done watchdog.
module uart_tx_scheduler #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ID_W           = 2,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned CNT_W          = 21
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   tx_ready,
    input  logic                   tx_done,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic [ID_W-1:0]        grant_id,
    output logic                   busy,
    output logic                   timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_DONE,
        S_HOLD
    } state_e;

    state_e               state_q;
    logic [ID_W-1:0]      last_q;
    logic                 lock_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [NUM_REQ-1:0]   req_ready_q;
    logic                 tx_start_q;
    logic [7:0]           tx_data_q;
    logic [ID_W-1:0]      grant_q;
    logic                 busy_q;
    logic                 timeout_q;

    logic [ID_W-1:0]      winner_d;
    int unsigned          idx;

    // Scan from the farthest offset down so the nearest valid index after last_q wins.
    always_comb begin
        winner_d = last_q;
        idx      = 0;
        for (int unsigned off = NUM_REQ; off > 0; off--) begin
            idx = (32'(last_q) + off) % NUM_REQ;
            if (req_valid[idx]) begin
                winner_d = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_q      <= ID_W'(NUM_REQ - 1);
            lock_q      <= 1'b0;
            cnt_q       <= '0;
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            timeout_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|req_valid) begin
                        grant_q <= winner_d;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    req_ready_q <= NUM_REQ'(1) << grant_q;
                    tx_data_q   <= req_data[8*grant_q +: 8];
                    lock_q      <= ~req_last[grant_q];
                    state_q     <= S_START;
                end
                S_START: begin
                    if (tx_ready) begin
                        tx_start_q <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    // tx_done is checked first so it wins over a coincident expiry.
                    if (tx_done) begin
                        if (lock_q) begin
                            cnt_q   <= '0;
                            state_q <= S_HOLD;
                        end else begin
                            last_q  <= grant_q;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_q <= 1'b1;
                        lock_q    <= 1'b0;
                        last_q    <= grant_q;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (req_valid[grant_q]) begin
                        state_q <= S_LOAD;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_q <= 1'b1;
                        lock_q    <= 1'b0;
                        last_q    <= grant_q;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: latency, round-robin order, burst lock,
// transmitter back-pressure, watchdog expiry and mid-operation reset.
module tb_uart_tx_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_ready;
    logic        tx_done;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_scheduler #(
        .NUM_REQ       (4),
        .ID_W          (2),
        .TIMEOUT_CYCLES(64),
        .CNT_W         (7)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .grant_id   (grant_id),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b1;
        tx_done   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic l, input logic v);
        req_data[8*i +: 8] = d;
        req_last[i]        = l;
        req_valid[i]       = v;
    endtask

    task automatic wait_ready(output logic [3:0] rdy, output bit ok);
        ok  = 1'b0;
        rdy = '0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready !== 4'b0000) begin
                rdy = req_ready;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_start(output logic [7:0] d, output logic [1:0] id, output bit ok);
        ok = 1'b0;
        d  = '0;
        id = '0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                d  = tx_data;
                id = grant_id;
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called on the sample where tx_start was seen; returns with the scheduler back in IDLE or HOLD.
    task automatic finish_byte(input int dly);
        tx_ready = 1'b0;
        repeat (dly) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done  = 1'b0;
        tx_ready = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] outs;
        rst_n     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b1;
        tx_done   = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        outs = {req_ready, tx_start, tx_data, grant_id, busy, timeout_err};
        n_vec++;
        if (outs !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_outputs: got %0h want 0", outs);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle_busy: got %0h want 0", busy);
        end
    endtask

    task automatic test_single();
        apply_reset();
        set_req(2, 8'h41, 1'b1, 1'b1);
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0000 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_cyc1: got ready=%0h busy=%0h want ready=0 busy=1", req_ready, busy);
        end
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0100) begin
            n_err++;
            $display("FAIL single_ready: got %0h want 4", req_ready);
        end
        n_vec++;
        if (tx_data !== 8'h41 || grant_id !== 2'd2 || tx_start !== 1'b0) begin
            n_err++;
            $display("FAIL single_load: got data=%0h id=%0h start=%0h want 41 2 0", tx_data, grant_id, tx_start);
        end
        req_valid[2] = 1'b0;
        @(negedge clk);
        n_vec++;
        if (tx_start !== 1'b1 || req_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL single_start: got start=%0h ready=%0h want 1 0", tx_start, req_ready);
        end
        tx_ready = 1'b0;
        @(negedge clk);
        n_vec++;
        if (tx_start !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_pulse: got start=%0h busy=%0h want 0 1", tx_start, busy);
        end
        repeat (98) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done  = 1'b0;
        tx_ready = 1'b1;
        n_vec++;
        if (busy !== 1'b0 || grant_id !== 2'd2 || tx_data !== 8'h41) begin
            n_err++;
            $display("FAIL single_done: got busy=%0h id=%0h data=%0h want 0 2 41", busy, grant_id, tx_data);
        end
    endtask

    task automatic test_round_robin();
        int         order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] rdy;
        logic [7:0] d;
        logic [1:0] id;
        bit         ok;
        apply_reset();
        for (int i = 0; i < 4; i++) set_req(i, 8'(8'h10 + i), 1'b1, 1'b1);
        for (int m = 0; m < 5; m++) begin
            wait_ready(rdy, ok);
            n_vec++;
            if (!ok || rdy !== 4'(1 << order[m])) begin
                n_err++;
                $display("FAIL rr_ready[%0d]: got %0h want %0h", m, rdy, 4'(1 << order[m]));
            end
            wait_start(d, id, ok);
            n_vec++;
            if (!ok || id !== 2'(order[m]) || d !== 8'(8'h10 + order[m])) begin
                n_err++;
                $display("FAIL rr_start[%0d]: got id=%0h data=%0h want %0h %0h", m, id, d, order[m], 8'h10 + order[m]);
            end
            finish_byte(3);
        end
    endtask

    task automatic test_burst();
        logic [3:0] rdy;
        logic [7:0] d;
        logic [1:0] id;
        bit         ok;
        apply_reset();
        set_req(0, 8'hA0, 1'b0, 1'b1);
        set_req(1, 8'hB1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            wait_ready(rdy, ok);
            n_vec++;
            if (!ok || rdy !== 4'b0001) begin
                n_err++;
                $display("FAIL burst_ready[%0d]: got %0h want 1", k, rdy);
            end
            if (k < 2) set_req(0, 8'(8'hA1 + k), (k == 1), 1'b1);
            else       req_valid[0] = 1'b0;
            wait_start(d, id, ok);
            n_vec++;
            if (!ok || id !== 2'd0 || d !== 8'(8'hA0 + k)) begin
                n_err++;
                $display("FAIL burst_byte[%0d]: got id=%0h data=%0h want 0 %0h", k, id, d, 8'hA0 + k);
            end
            finish_byte(4);
        end
        wait_ready(rdy, ok);
        n_vec++;
        if (!ok || rdy !== 4'b0010) begin
            n_err++;
            $display("FAIL burst_next_ready: got %0h want 2", rdy);
        end
        req_valid[1] = 1'b0;
        wait_start(d, id, ok);
        n_vec++;
        if (!ok || id !== 2'd1 || d !== 8'hB1) begin
            n_err++;
            $display("FAIL burst_next_byte: got id=%0h data=%0h want 1 b1", id, d);
        end
        finish_byte(3);
    endtask

    task automatic test_ready_stall();
        logic [3:0] rdy;
        bit         ok;
        int         bad = 0;
        apply_reset();
        tx_ready = 1'b0;
        set_req(1, 8'h5A, 1'b1, 1'b1);
        wait_ready(rdy, ok);
        n_vec++;
        if (!ok || rdy !== 4'b0010) begin
            n_err++;
            $display("FAIL stall_ready: got %0h want 2", rdy);
        end
        req_valid[1] = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (tx_start !== 1'b0 || tx_data !== 8'h5A) bad++;
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL stall_hold: got %0d bad cycles want 0", bad);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (tx_start !== 1'b1 || tx_data !== 8'h5A) begin
            n_err++;
            $display("FAIL stall_release: got start=%0h data=%0h want 1 5a", tx_start, tx_data);
        end
        finish_byte(3);
    endtask

    task automatic test_timeout();
        logic [3:0] rdy;
        logic [7:0] d;
        logic [1:0] id;
        bit         ok;
        int         found = 0;
        apply_reset();
        set_req(1, 8'h33, 1'b1, 1'b1);
        wait_ready(rdy, ok);
        req_valid[1] = 1'b0;
        wait_start(d, id, ok);
        n_vec++;
        if (!ok || id !== 2'd1) begin
            n_err++;
            $display("FAIL to_start: got id=%0h want 1", id);
        end
        tx_ready = 1'b0;
        set_req(0, 8'h40, 1'b1, 1'b1);
        set_req(2, 8'h42, 1'b1, 1'b1);
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (timeout_err === 1'b1) begin
                found = k;
                break;
            end
        end
        n_vec++;
        if (found !== 64) begin
            n_err++;
            $display("FAIL to_delay: got %0d want 64", found);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL to_idle: got busy=%0h want 0", busy);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL to_pulse: got %0h want 0", timeout_err);
        end
        wait_ready(rdy, ok);
        n_vec++;
        if (!ok || rdy !== 4'b0100) begin
            n_err++;
            $display("FAIL to_next_ready: got %0h want 4", rdy);
        end
        req_valid[2] = 1'b0;
        wait_start(d, id, ok);
        n_vec++;
        if (!ok || id !== 2'd2 || d !== 8'h42) begin
            n_err++;
            $display("FAIL to_next_byte: got id=%0h data=%0h want 2 42", id, d);
        end
        finish_byte(3);
    endtask

    task automatic test_hold_timeout();
        logic [3:0] rdy;
        logic [7:0] d;
        logic [1:0] id;
        bit         ok;
        int         found = 0;
        int         stray = 0;
        apply_reset();
        set_req(1, 8'hC0, 1'b0, 1'b1);
        wait_ready(rdy, ok);
        req_valid[1] = 1'b0;
        wait_start(d, id, ok);
        n_vec++;
        if (!ok || d !== 8'hC0) begin
            n_err++;
            $display("FAIL hold_start: got data=%0h want c0", d);
        end
        finish_byte(3);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL hold_busy: got %0h want 1", busy);
        end
        set_req(0, 8'h50, 1'b1, 1'b1);
        set_req(2, 8'h52, 1'b1, 1'b1);
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (req_ready !== 4'b0000) stray++;
            if (timeout_err === 1'b1) begin
                found = k;
                break;
            end
        end
        n_vec++;
        if (found !== 64) begin
            n_err++;
            $display("FAIL hold_delay: got %0d want 64", found);
        end
        n_vec++;
        if (stray !== 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL hold_ignore: got stray=%0d busy=%0h want 0 0", stray, busy);
        end
        wait_ready(rdy, ok);
        n_vec++;
        if (!ok || rdy !== 4'b0100) begin
            n_err++;
            $display("FAIL hold_next_ready: got %0h want 4", rdy);
        end
        req_valid[2] = 1'b0;
        wait_start(d, id, ok);
        finish_byte(3);
    endtask

    task automatic test_reset_mid();
        logic [3:0]  rdy;
        logic [7:0]  d;
        logic [1:0]  id;
        bit          ok;
        logic [15:0] outs;
        int          bad = 0;
        apply_reset();
        set_req(0, 8'h60, 1'b1, 1'b1);
        wait_ready(rdy, ok);
        req_valid[0] = 1'b0;
        wait_start(d, id, ok);
        finish_byte(3);
        set_req(2, 8'h77, 1'b1, 1'b1);
        wait_ready(rdy, ok);
        req_valid[2] = 1'b0;
        wait_start(d, id, ok);
        tx_ready = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        outs = {req_ready, tx_start, tx_data, grant_id, busy, timeout_err};
        n_vec++;
        if (outs !== 16'h0000) begin
            n_err++;
            $display("FAIL rstmid_outputs: got %0h want 0", outs);
        end
        tx_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (tx_start !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL rstmid_quiet: got %0d active cycles want 0", bad);
        end
        rst_n = 1'b1;
        set_req(0, 8'h61, 1'b1, 1'b1);
        set_req(1, 8'h71, 1'b1, 1'b1);
        wait_ready(rdy, ok);
        n_vec++;
        if (!ok || rdy !== 4'b0001) begin
            n_err++;
            $display("FAIL rstmid_prio: got %0h want 1", rdy);
        end
        req_valid[0] = 1'b0;
        wait_start(d, id, ok);
        n_vec++;
        if (!ok || id !== 2'd0 || d !== 8'h61) begin
            n_err++;
            $display("FAIL rstmid_byte: got id=%0h data=%0h want 0 61", id, d);
        end
        finish_byte(3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_ready_stall();
        test_timeout();
        test_hold_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
